// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores to the data bus with
// byte-lane steering, holds the request until ack, forwards register
// results to writeback, and aligns/extends returned load data.
//
// Handshake: an ALU result transfers on a rising edge where iValid & oReady
// are both high; oReady is high exactly when the stage is IDLE, and the
// producer must hold its fields stable while iValid is high and oReady low.
module mem_access_stage #(
  parameter int cXLEN     = 32,
  parameter int cRegAddrW = 5
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic                 iMemRead,
  input  logic                 iMemWrite,
  input  logic [2:0]           iOpType,
  input  logic [cXLEN-1:0]     iAddr,
  input  logic [cXLEN-1:0]     iWrData,
  input  logic [cRegAddrW-1:0] iRdAddr,
  input  logic                 iRegDv,
  input  logic [cRegAddrW-1:0] iRegAddr,
  input  logic [cXLEN-1:0]     iRegData,
  output logic                 oMemReq,
  output logic                 oMemWe,
  output logic [cXLEN-1:0]     oMemAddr,
  output logic [3:0]           oMemBe,
  output logic [cXLEN-1:0]     oMemWrData,
  input  logic                 iMemAck,
  input  logic [cXLEN-1:0]     iMemRdData,
  output logic                 oWbDv,
  output logic [cRegAddrW-1:0] oWbAddr,
  output logic [cXLEN-1:0]     oWbData,
  output logic                 oExcept,
  output logic                 oDbgState
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state;
  logic [2:0]             ld_type;
  logic [1:0]             ld_lane;
  logic [cRegAddrW-1:0]   ld_rd;

  logic                   is_mem;
  logic                   op_legal;
  logic                   op_aligned;
  logic [3:0]             be_next;
  logic [cXLEN-1:0]       wdata_next;
  logic [cXLEN-1:0]       rd_shifted;
  logic [cXLEN-1:0]       ld_value;
  logic                   accept;

  assign oReady    = (state == IDLE);
  assign oDbgState = (state == BUSY);
  assign is_mem    = iMemRead | iMemWrite;
  assign accept    = iValid & oReady;

  // Decode legality, alignment, byte enables and steered store data of the incoming op
  always_comb begin
    op_legal   = 1'b0;
    op_aligned = 1'b1;
    be_next    = 4'b1111;
    wdata_next = '0;
    if (iMemRead && iMemWrite) begin
      op_legal = 1'b0;
    end else if (iMemRead) begin
      op_legal = (iOpType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (iMemWrite) begin
      op_legal = (iOpType inside {3'b000, 3'b001, 3'b010});
    end
    case (iOpType[1:0])
      2'b00: begin
        be_next = 4'b0001 << iAddr[1:0];
        if (iMemWrite) wdata_next = {4{iWrData[7:0]}};
      end
      2'b01: begin
        op_aligned = ~iAddr[0];
        be_next    = iAddr[1] ? 4'b1100 : 4'b0011;
        if (iMemWrite) wdata_next = {2{iWrData[15:0]}};
      end
      default: begin
        op_aligned = (iAddr[1:0] == 2'b00);
        be_next    = 4'b1111;
        if (iMemWrite) wdata_next = iWrData;
      end
    endcase
  end

  // Align the returned word to the addressed lane and sign/zero-extend it
  always_comb begin
    rd_shifted = iMemRdData >> {ld_lane, 3'b000};
    case (ld_type)
      3'b000:  ld_value = {{(cXLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  ld_value = {{(cXLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  ld_value = {{(cXLEN-8){1'b0}}, rd_shifted[7:0]};
      3'b101:  ld_value = {{(cXLEN-16){1'b0}}, rd_shifted[15:0]};
      default: ld_value = rd_shifted;
    endcase
  end

  // IDLE/BUSY controller with registered bus, writeback and exception outputs
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      oMemReq    <= 1'b0;
      oMemWe     <= 1'b0;
      oMemAddr   <= '0;
      oMemBe     <= '0;
      oMemWrData <= '0;
      oWbDv      <= 1'b0;
      oWbAddr    <= '0;
      oWbData    <= '0;
      oExcept    <= 1'b0;
      ld_type    <= '0;
      ld_lane    <= '0;
      ld_rd      <= '0;
    end else begin
      oWbDv   <= 1'b0;
      oExcept <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem) begin
              if (op_legal && op_aligned) begin
                oMemReq    <= 1'b1;
                oMemWe     <= iMemWrite;
                oMemAddr   <= {iAddr[cXLEN-1:2], 2'b00};
                oMemBe     <= be_next;
                oMemWrData <= wdata_next;
                ld_type    <= iOpType;
                ld_lane    <= iAddr[1:0];
                ld_rd      <= iRdAddr;
                state      <= BUSY;
              end else begin
                oExcept <= 1'b1;
              end
            end else begin
              oWbDv   <= iRegDv & (iRegAddr != '0);
              oWbAddr <= iRegAddr;
              oWbData <= iRegData;
            end
          end
        end
        BUSY: begin
          if (iMemAck) begin
            oMemReq <= 1'b0;
            state   <= IDLE;
            if (!oMemWe) begin
              oWbDv   <= (ld_rd != '0);
              oWbAddr <= ld_rd;
              oWbData <= ld_value;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
